// File: rtl/uart_boot_loader.sv
// uart_boot_loader: turns a framed UART byte stream (sync, 16-bit word count,
// payload, 8-bit checksum) into 32-bit little-endian SRAM writes, and keeps
// the CPU in reset until the whole image is written and the checksum matches.
module uart_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 8192,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    output logic        cpu_resetn,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    // Word count limit widened by one bit so the compare cannot overflow.
    localparam logic [16:0] MAX_W = MAX_WORDS[16:0];

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic [31:0] word_q, word_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        cpu_resetn_q, cpu_resetn_d;

    logic        accept;
    logic [15:0] len_new;
    logic [31:0] word_nxt;

    // Upstream is stalled only while a word is in flight to SRAM; the rst
    // term keeps in_ready low for the whole reset window.
    assign in_ready = ~rst & (state_q != S_WRITE);
    assign accept   = in_valid & in_ready;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        byte_cnt_d   = byte_cnt_q;
        sum_d        = sum_q;
        word_d       = word_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        done_d       = done_q;
        error_d      = error_q;
        cpu_resetn_d = cpu_resetn_q;
        len_new      = {in_data, len_q[7:0]};
        word_nxt     = word_q;

        case (byte_cnt_q)
            2'd0:    word_nxt[7:0]   = in_data;
            2'd1:    word_nxt[15:8]  = in_data;
            2'd2:    word_nxt[23:16] = in_data;
            default: word_nxt[31:24] = in_data;
        endcase

        case (state_q)
            S_IDLE: begin
                if (accept && in_data == SYNC_BYTE) state_d = S_LEN0;
            end
            S_LEN0: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d      = len_new;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    sum_d      = '0;
                    if (len_new == 16'd0) begin
                        state_d = S_CSUM;
                    end else if ({1'b0, len_new} > MAX_W) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d     = word_nxt;
                    sum_d      = sum_q + in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Launch the write from registers so it appears the
                    // cycle after the last byte and holds until mem_ready.
                    if (byte_cnt_q == 2'd3) begin
                        state_d     = S_WRITE;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                        mem_wdata_d = word_nxt;
                        mem_wstrb_d = 4'hF;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = 4'h0;
                    word_idx_d  = word_idx_q + 16'd1;
                    if (word_idx_q + 16'd1 == len_q) state_d = S_CSUM;
                    else                             state_d = S_DATA;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (in_data == sum_q) begin
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        cpu_resetn_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; async reset parks everything at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            sum_q        <= '0;
            word_q       <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_resetn_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            sum_q        <= sum_d;
            word_q       <= word_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_resetn_q <= cpu_resetn_d;
        end
    end

    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_resetn = cpu_resetn_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: byte driver, SRAM responder with a
// programmable ready delay, and a write log checked against hand values.
module tb_uart_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic        cpu_resetn;
    logic        done;
    logic        error;

    int checks = 0;
    int failures = 0;

    int          mem_delay = 1;
    int          wcnt = 0;
    bit          acked = 1'b0;
    int          nw = 0;
    logic [31:0] wr_addr [0:15];
    logic [31:0] wr_data [0:15];
    logic [31:0] h_addr, h_data;

    uart_boot_loader dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .cpu_resetn(cpu_resetn), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // SRAM responder: ack after mem_delay cycles of mem_valid, check the
    // request holds steady and upstream is stalled while it waits.
    always @(negedge clk) begin
        if (rst) begin
            mem_ready = 1'b0;
            wcnt = 0;
            acked = 1'b0;
        end else begin
            if (acked) begin
                chk("mv_drop", {31'd0, mem_valid}, 32'd0);
                acked = 1'b0;
            end
            if (mem_valid) begin
                chk("wr_inrdy", {31'd0, in_ready}, 32'd0);
                chk("wr_strb", {28'd0, mem_wstrb}, 32'hF);
                if (wcnt == 0) begin
                    h_addr = mem_addr;
                    h_data = mem_wdata;
                end else begin
                    chk("hold_addr", mem_addr, h_addr);
                    chk("hold_data", mem_wdata, h_data);
                end
                if (wcnt == mem_delay) begin
                    mem_ready = 1'b1;
                    if (nw < 16) begin
                        wr_addr[nw] = mem_addr;
                        wr_data[nw] = mem_wdata;
                    end
                    nw++;
                    wcnt = 0;
                    acked = 1'b1;
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] b [], input int n);
        for (int i = 0; i < n; i++) send_byte(b[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_inrdy", {31'd0, in_ready}, 32'd0);
        chk("rst_mvalid", {31'd0, mem_valid}, 32'd0);
        chk("rst_strb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_flags", {29'd0, cpu_resetn, done, error}, 32'd0);
        rst = 1'b0;
        nw = 0;
    endtask

    task automatic chk_flags(input string tag, input logic d, input logic e, input logic c);
        chk(tag, {29'd0, done, error, cpu_resetn}, {29'd0, d, e, c});
    endtask

    logic [7:0] seq [];

    initial begin
        // Garbage, then one-word frame
        do_reset();
        mem_delay = 1;
        seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_seq(seq, 9);
        chk("t1_latency", {31'd0, mem_valid}, 32'd1);
        send_byte(8'h14);
        chk_flags("t1_flags", 1'b1, 1'b0, 1'b1);
        chk("t1_nw", nw, 1);
        chk("t1_addr", wr_addr[0], 32'h0);
        chk("t1_data", wr_data[0], 32'h1234_5678);
        send_byte(8'h55);
        chk_flags("t1_after", 1'b1, 1'b0, 1'b1);

        // Two words, stalling SRAM
        do_reset();
        mem_delay = 3;
        seq = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
        send_seq(seq, 12);
        chk_flags("t2_flags", 1'b1, 1'b0, 1'b1);
        chk("t2_nw", nw, 2);
        chk("t2_a0", wr_addr[0], 32'h0);
        chk("t2_d0", wr_data[0], 32'h0403_0201);
        chk("t2_a1", wr_addr[1], 32'h4);
        chk("t2_d1", wr_data[1], 32'h0807_0605);

        // Bad checksum, then a valid frame that must be ignored
        do_reset();
        mem_delay = 1;
        seq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
        send_seq(seq, 8);
        chk_flags("t3_flags", 1'b0, 1'b1, 1'b0);
        chk("t3_nw", nw, 1);
        chk("t3_d0", wr_data[0], 32'h0000_0001);
        seq = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        send_seq(seq, 8);
        chk_flags("t3_sticky", 1'b0, 1'b1, 1'b0);
        chk("t3_nw2", nw, 1);

        // Zero-length frames
        do_reset();
        seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(seq, 4);
        chk_flags("t4_len0_ok", 1'b1, 1'b0, 1'b1);
        chk("t4_nw", nw, 0);
        do_reset();
        seq = '{8'hA5, 8'h00, 8'h00, 8'h01};
        send_seq(seq, 4);
        chk_flags("t4_len0_bad", 1'b0, 1'b1, 1'b0);

        // Length 8193 rejected right after LEN1
        do_reset();
        seq = '{8'hA5, 8'h01, 8'h20};
        send_seq(seq, 3);
        chk_flags("t4_toolong", 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_toolong_nw", nw, 0);

        // Reset asserted during the second WRITE
        do_reset();
        mem_delay = 3;
        seq = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08};
        send_seq(seq, 11);
        begin
            int t = 0;
            while (!mem_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
        end
        chk("t5_in_write", {31'd0, mem_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_mv_clr", {31'd0, mem_valid}, 32'd0);
        chk("t5_cpu_rst", {31'd0, cpu_resetn}, 32'd0);
        chk("t5_nw", nw, 1);
        do_reset();
        mem_delay = 1;
        chk_flags("t5_idle", 1'b0, 1'b0, 1'b0);
        seq = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        send_seq(seq, 8);
        chk_flags("t5_reload", 1'b1, 1'b0, 1'b1);
        chk("t5_rl_nw", nw, 1);
        chk("t5_rl_data", wr_data[0], 32'h1234_5678);

        // Checksum wrap
        do_reset();
        seq = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC};
        send_seq(seq, 8);
        chk_flags("t6_flags", 1'b1, 1'b0, 1'b1);
        chk("t6_data", wr_data[0], 32'hFFFF_FFFF);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so a stuck handshake still reaches a verdict.
    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", 1);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Boot-time loader that sits between the UART byte receiver and the SoC memory bus, ahead of the CPU. It takes a framed byte stream (sync, length, payload, checksum), packs the payload into 32-bit little-endian words and writes them into SRAM through a native valid/ready memory-bus master port. It holds the CPU in reset until the image has been written and the checksum matches.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_0000: SRAM byte address of the first payload word.
- `MAX_WORDS`, default 8192: largest accepted word count. This is 32 KiB of SRAM.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: a received byte is available.
- `in_data`, in, 8: the received byte.
- `in_ready`, out, 1: the loader accepts the byte this cycle.
- `mem_valid`, out, 1: write request to SRAM.
- `mem_addr`, out, 32: word-aligned byte address.
- `mem_wdata`, out, 32: write data.
- `mem_wstrb`, out, 4: byte enables. The value is 4'hF during a write and 4'h0 otherwise.
- `mem_ready`, in, 1: SRAM has completed the write.
- `cpu_resetn`, out, 1: active-low reset for the CPU. Released only after a successful load.
- `done`, out, 1: image loaded and checksum correct.
- `error`, out, 1: the frame was rejected.

## Operation
- A byte is accepted in any cycle where `in_valid && in_ready`.
- States: IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR.
- **IDLE**
  - An accepted byte equal to `SYNC_BYTE` moves to LEN0.
  - Any other byte is discarded and the state stays IDLE.
- **LEN0**
  - The accepted byte becomes `len[7:0]`.
  - Next state is LEN1.
- **LEN1**
  - The accepted byte becomes `len[15:8]`.
  - If `len == 0`, go to CSUM.
  - If `len > MAX_WORDS`, go to ERR.
  - Otherwise go to DATA, with `word_idx = 0`, `byte_cnt = 0` and `sum = 0`.
- **DATA**
  - Each accepted byte goes into byte lane `byte_cnt`: byte 0 fills [7:0], byte 3 fills [31:24].
  - Each accepted byte is added to `sum` (8-bit, wraps mod 256).
  - When the 4th byte is accepted, go to WRITE.
- **WRITE**
  - `mem_valid` = 1.
  - `mem_addr = BASE_ADDR + {word_idx, 2'b00}`, as a 32-bit add that wraps.
  - `mem_wdata` = the assembled word; `mem_wstrb` = 4'hF.
  - `in_ready` = 0.
  - When `mem_ready` is sampled high, `word_idx` increments.
  - If `word_idx + 1 == len`, go to CSUM; otherwise return to DATA.
- **CSUM**
  - An accepted byte equal to `sum` goes to DONE.
  - A mismatching byte goes to ERR.
- **DONE**
  - `done` = 1 and `cpu_resetn` = 1.
  - `in_ready` = 1; all further bytes are accepted and dropped.
  - The block stays in DONE until `rst`.
- **ERR**
  - `error` = 1 and `cpu_resetn` = 0.
  - `in_ready` = 1; bytes are dropped.
  - The block stays in ERR until `rst`. There is no automatic retry.
- The sync byte and the length bytes are not included in the checksum.

## Timing
- **While `rst` is high:**
  - State is IDLE.
  - `in_ready` = 0, `mem_valid` = 0, `mem_wstrb` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `cpu_resetn` = 0, `done` = 0, `error` = 0.
  - All counters and `sum` are 0.
- **`in_ready`:**
  - Decoded from the state: 1 in every state except WRITE, and 0 during reset.
  - A byte offered during WRITE is held by the upstream source. It is never lost.
- **Write latency:** `mem_valid` rises in the cycle after the 4th payload byte is accepted, because the state register moves to WRITE.
- **Write hold:**
  - `mem_valid`, `mem_addr`, `mem_wdata` and `mem_wstrb` are registered.
  - They stay stable from `mem_valid` rising until the clock edge that samples `mem_ready` = 1.
  - `mem_valid` is 0 in the cycle after that edge.
  - `mem_ready` while `mem_valid` = 0 is ignored.
- **Throughput:** at least 1 cycle of `in_ready` = 0 per word. With SRAM `mem_ready` arriving one cycle after `mem_valid`, each word costs 4 byte cycles plus 2 WRITE cycles.
- **Success outputs:** `done` and `cpu_resetn` rise together in the cycle after the matching checksum byte is accepted. Both are registered and glitch-free.
- **Error output:** `error` rises in the cycle after the offending LEN1 or CSUM byte is accepted.
- **Reset mid-operation:**
  - Asserting `rst` in any state, including WRITE with `mem_valid` high, immediately clears `mem_valid` and `cpu_resetn`.
  - The partial image in SRAM is not cleaned up.

## Test plan
- **Garbage then valid frame:** 00 FF A5 01 00 78 56 34 12 14 → exactly one write: addr 0x0, data 0x12345678, strb F. `done` = 1, `cpu_resetn` = 1, `error` = 0.
- **Two words with a stalling SRAM:** A5 02 00, then 01 02 03 04 05 06 07 08, then checksum 24; `mem_ready` delayed 3 cycles → writes 0x04030201 @0x0 and 0x08070605 @0x4. Address, data and strobe stay stable while `mem_ready` is low, and `in_ready` = 0 throughout each WRITE.
- **Bad checksum:** A5 01 00 01 00 00 00 FF → one write, then `error` = 1, `done` = 0, `cpu_resetn` = 0. A following valid frame is ignored until `rst`.
- **Length boundaries:**
  - A5 00 00 00 → `done` with no write.
  - A5 00 00 01 → `error`.
  - A5 01 20 → `error` after the LEN1 byte (len 8193 > 8192), with no write.
- **Reset mid-load:** assert `rst` during the second WRITE → `mem_valid` = 0 immediately. After release the state is IDLE and a full frame loads correctly.
- **Checksum wrap:** payload FF FF FF FF, checksum FC → `done` = 1.
